// File: rtl/swu_pkg.sv
// swu_pkg: shared enums and sizing helpers for the sliding-window line-buffer scheduler
package swu_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, RESTART} state_e;
  function automatic int ofm_dim(int ifm, int k, int s);
    return (ifm - k) / s + 1;
  endfunction
  function automatic int used_rows(int ifm, int k, int s);
    return (ofm_dim(ifm, k, s) - 1) * s + k;
  endfunction
  function automatic int cw(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/swu_ring_ptr.sv
// swu_ring_ptr: modulo-N slot pointer (clk, rst, clr, adv in; ptr out) advancing by STEP via compare-and-subtract
module swu_ring_ptr #(
  parameter int N = 4,
  parameter int STEP = 1,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] ptr
);
  logic [W:0] sum;
  logic [W-1:0] ptr_d, ptr_q;
  always_comb begin
    sum = {1'b0, ptr_q} + (W+1)'(STEP);
    ptr_d = clr ? '0 : !adv ? ptr_q : sum >= (W+1)'(N) ? W'(sum - (W+1)'(N)) : W'(sum);
  end
  always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
  assign ptr = ptr_q;
endmodule

// File: rtl/swu_buffer_scheduler.sv
// swu_buffer_scheduler: line-buffer frame sequencer; writer handshake (wr_*), reader grant/done (rd_*), occupancy, frame_restart
module swu_buffer_scheduler
  import swu_pkg::*;
#(
  parameter int IFM_DIM = 8,
  parameter int K = 3,
  parameter int STRIDE = 2,
  parameter int BUFFER_ROWS = 4
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          wr_en,
  output logic [cw(BUFFER_ROWS)-1:0]    wr_row,
  output logic [cw(IFM_DIM)-1:0]        wr_col,
  input  logic                          rd_req,
  output logic                          rd_grant,
  output logic [cw(BUFFER_ROWS)-1:0]    rd_base_row,
  input  logic                          rd_done,
  output logic [cw(BUFFER_ROWS+1)-1:0]  occupancy,
  output logic                          frame_restart
);
  localparam int OFM = ofm_dim(IFM_DIM, K, STRIDE);
  localparam int USED = used_rows(IFM_DIM, K, STRIDE);
  localparam int RW = cw(BUFFER_ROWS);
  localparam int CW = cw(IFM_DIM);
  localparam int OW = cw(BUFFER_ROWS + 1);
  localparam int IW = cw(IFM_DIM + 1);
  localparam int UW = cw(OFM + 1);
  state_e state_d, state_q;
  logic [CW-1:0] wr_col_d, wr_col_q;
  logic [IW-1:0] in_row_d, in_row_q;
  logic [UW-1:0] out_row_d, out_row_q;
  logic [OW-1:0] occ_d, occ_q;
  logic rd_busy_d, rd_busy_q, rd_grant_d, rd_grant_q;
  logic hs, col_wrap, commit, rel, last, restart, grant_cond;
  always_ff @(posedge aclk)
    if (areset) begin
      state_q <= RUN;
      wr_col_q <= '0;
      in_row_q <= '0;
      out_row_q <= '0;
      occ_q <= '0;
      rd_busy_q <= 1'b0;
      rd_grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_col_q <= wr_col_d;
      in_row_q <= in_row_d;
      out_row_q <= out_row_d;
      occ_q <= occ_d;
      rd_busy_q <= rd_busy_d;
      rd_grant_q <= rd_grant_d;
    end
  always_comb
    state_d = state_q == RUN ? (last ? (in_row_q < IW'(IFM_DIM) ? DRAIN : RESTART) : RUN)
            : state_q == DRAIN ? (col_wrap && in_row_q == IW'(IFM_DIM - 1) ? RESTART : DRAIN)
            : RUN;
  always_comb begin
    wr_ready = state_q == RUN ? (occ_q < OW'(BUFFER_ROWS)) && (in_row_q < IW'(USED)) : state_q == DRAIN;
    wr_en = hs && state_q == RUN;
    frame_restart = state_q == RESTART;
  end
  // counters hold their terminal values through RESTART and clear on the edge leaving it
  always_comb begin
    restart = state_q == RESTART;
    hs = wr_valid & wr_ready;
    col_wrap = hs && wr_col_q == CW'(IFM_DIM - 1);
    commit = col_wrap && state_q == RUN;
    rel = rd_done & rd_busy_q;
    last = rel && out_row_q == UW'(OFM - 1);
    grant_cond = rd_req && !rd_busy_q && occ_q >= OW'(K) && out_row_q < UW'(OFM) && state_q == RUN;
    wr_col_d = restart || col_wrap ? '0 : hs ? wr_col_q + 1'b1 : wr_col_q;
    in_row_d = restart ? '0 : in_row_q + IW'(col_wrap);
    out_row_d = restart ? '0 : out_row_q + UW'(rel);
    occ_d = restart || last ? '0 : occ_q + OW'(commit) - (rel ? OW'(STRIDE) : '0);
    rd_busy_d = !restart && (grant_cond || (rd_busy_q && !rel));
    rd_grant_d = grant_cond;
  end
  swu_ring_ptr #(.N(BUFFER_ROWS), .STEP(1), .W(RW)) u_wr_ptr (
    .clk(aclk), .rst(areset), .clr(restart), .adv(commit), .ptr(wr_row)
  );
  swu_ring_ptr #(.N(BUFFER_ROWS), .STEP(STRIDE), .W(RW)) u_rd_ptr (
    .clk(aclk), .rst(areset), .clr(restart), .adv(rel && !last), .ptr(rd_base_row)
  );
  assign wr_col = wr_col_q;
  assign occupancy = occ_q;
  assign rd_grant = rd_grant_q;
endmodule

// File: tb/tb_swu_buffer_scheduler.sv
// tb_swu_buffer_scheduler: directed scoreboard bench for swu_buffer_scheduler (IFM 8, K 3, STRIDE 2, 4 slots)
module tb_swu_buffer_scheduler;
  logic aclk = 1'b0, areset = 1'b1, wr_valid = 1'b0, rd_req = 1'b0, rd_done = 1'b0;
  logic wr_ready, wr_en, rd_grant, frame_restart;
  logic [1:0] wr_row, rd_base_row;
  logic [2:0] wr_col, occupancy;
  int checks = 0, failures = 0;
  int grants, hs_cnt, wren_cnt, restarts, tick_n, last_hs_tick, restart_tick, rd_cnt;
  bit auto_rd;
  logic [1:0] exp_base[$];
  always #5 aclk = ~aclk;
  swu_buffer_scheduler dut (
    .aclk(aclk), .areset(areset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_en(wr_en),
    .wr_row(wr_row), .wr_col(wr_col), .rd_req(rd_req), .rd_grant(rd_grant),
    .rd_base_row(rd_base_row), .rd_done(rd_done), .occupancy(occupancy), .frame_restart(frame_restart)
  );
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge aclk);
    if (wr_valid && wr_ready) begin
      hs_cnt++;
      last_hs_tick = tick_n;
    end
    if (wr_en) wren_cnt++;
    @(posedge aclk);
    #1;
    if (rd_grant) begin
      grants++;
      if (exp_base.size() == 0) chk("grant_unexpected", rd_grant, 0);
      else chk("grant_base", rd_base_row, exp_base.pop_front());
    end
    if (frame_restart) begin
      restarts++;
      restart_tick = tick_n;
    end
    if (auto_rd) begin
      rd_done = 1'b0;
      if (rd_grant) rd_cnt = 10;
      else if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) rd_done = 1'b1;
      end
    end
    tick_n++;
  endtask
  task automatic clear_counts();
    grants = 0; hs_cnt = 0; wren_cnt = 0; restarts = 0;
    last_hs_tick = -1; restart_tick = -2; rd_cnt = 0;
    exp_base.delete();
  endtask
  task automatic do_reset();
    areset = 1'b1; wr_valid = 1'b0; rd_req = 1'b0; rd_done = 1'b0; auto_rd = 1'b0;
    tick();
    tick();
    areset = 1'b0;
    clear_counts();
  endtask
  task automatic check_idle(string p);
    chk({p, "_occ"}, occupancy, 0);
    chk({p, "_wr_row"}, wr_row, 0);
    chk({p, "_wr_col"}, wr_col, 0);
    chk({p, "_rd_base"}, rd_base_row, 0);
    chk({p, "_rd_grant"}, rd_grant, 0);
    chk({p, "_restart"}, frame_restart, 0);
  endtask
  task automatic run_frame(string p);
    clear_counts();
    exp_base.push_back(2'd0);
    exp_base.push_back(2'd2);
    exp_base.push_back(2'd0);
    auto_rd = 1'b1; rd_req = 1'b1; wr_valid = 1'b1;
    for (int n = 0; n < 800 && restarts == 0; n++) tick();
    wr_valid = 1'b0; rd_req = 1'b0; auto_rd = 1'b0; rd_done = 1'b0;
    chk({p, "_restart_seen"}, restarts, 1);
    chk({p, "_restart_timing"}, restart_tick, last_hs_tick);
    chk({p, "_hs"}, hs_cnt, 64);
    chk({p, "_wr_en"}, wren_cnt, 56);
    chk({p, "_grants"}, grants, 3);
    chk({p, "_grants_left"}, exp_base.size(), 0);
    tick();
    check_idle({p, "_after"});
    chk({p, "_restart_once"}, restarts, 1);
  endtask
  initial begin
    tick_n = 0;
    do_reset();
    check_idle("rst");
    chk("rst_wr_ready", wr_ready, 1);
    wr_valid = 1'b1;
    repeat (24) tick();
    wr_valid = 1'b0;
    chk("s1_occ", occupancy, 3);
    chk("s1_wr_row", wr_row, 3);
    chk("s1_wr_col", wr_col, 0);
    rd_req = 1'b1;
    exp_base.push_back(2'd0);
    tick();
    rd_req = 1'b0;
    chk("s1_grant", grants, 1);
    tick();
    chk("s1_pulse", rd_grant, 0);
    wr_valid = 1'b1;
    repeat (7) tick();
    chk("s3_col7", wr_col, 7);
    chk("s3_occ_pre", occupancy, 3);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0; wr_valid = 1'b0;
    chk("s3_occ", occupancy, 2);
    chk("s3_rd_base", rd_base_row, 2);
    chk("s3_wr_row", wr_row, 0);
    chk("s3_wr_col", wr_col, 0);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0; rd_req = 1'b1;
    repeat (4) tick();
    rd_req = 1'b0;
    chk("s6_no_grant", grants, 1);
    chk("s6_occ", occupancy, 2);
    chk("s6_rd_base", rd_base_row, 2);
    chk("s6_wr_row", wr_row, 0);
    chk("s6_wr_col", wr_col, 0);
    do_reset();
    wr_valid = 1'b1;
    repeat (32) tick();
    chk("s2_hs", hs_cnt, 32);
    chk("s2_occ", occupancy, 4);
    chk("s2_wr_ready", wr_ready, 0);
    chk("s2_wr_row", wr_row, 0);
    wren_cnt = 0;
    repeat (20) tick();
    chk("s2_hold_wr_en", wren_cnt, 0);
    chk("s2_hold_occ", occupancy, 4);
    chk("s2_hold_ready", wr_ready, 0);
    do_reset();
    run_frame("s4");
    do_reset();
    exp_base.push_back(2'd0);
    exp_base.push_back(2'd2);
    auto_rd = 1'b1; rd_req = 1'b1; wr_valid = 1'b1;
    for (int n = 0; n < 400 && hs_cnt < 43; n++) tick();
    chk("s5_reached_row5", hs_cnt, 43);
    areset = 1'b1; wr_valid = 1'b0; rd_req = 1'b0; auto_rd = 1'b0; rd_done = 1'b0;
    tick();
    check_idle("s5_abort");
    chk("s5_abort_ready", wr_ready, 1);
    chk("s5_abort_wr_en", wr_en, 0);
    areset = 1'b0;
    run_frame("s5");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
